lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store stage that sits directly downstream of the core ALU. It takes the ALU result as the effective address for LW/LBU/SW/SB and drives a request/grant/rvalid handshake to data memory. It stalls the upstream pipeline while an access is outstanding and returns formatted load data for writeback. Non-memory instructions pass through with no stall and no memory traffic.

## Interface
- MEM_ADDR_W, default 10: word-address width driven to data memory.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- valid_i  in  1  an instruction is presented this cycle.
- load_i  in  1  instruction is LW or LBU.
- store_i  in  1  instruction is SW or SB.
- byte_i  in  1  byte-sized access (LBU/SB); 0 means word (LW/SW).
- addr_i  in  32  byte address (ALU result).
- wdata_i  in  32  store data; SB uses [7:0].
- stall_o  out  1  freeze upstream stages this cycle.
- done_o  out  1  one-cycle pulse: access complete.
- rdata_o  out  32  load result, valid when done_o on a load; holds between loads.
- err_o  out  1  misaligned-word pulse (see Configuration).
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  MEM_ADDR_W  word address = addr_i[MEM_ADDR_W+1:2].
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: accept when valid_i and exactly one of load_i/store_i is set. On accept, register the word address, we, be and wdata, then go to REQ. valid_i with both or neither flag set is a no-op: no stall, no access.
- stall_o = (IDLE & accept) | REQ | WAIT. The stall is combinational in IDLE, so the instruction is held in the same cycle it appears.
- REQ: mem_req_o=1. Address, we, be and wdata stay stable until mem_gnt_i. On grant, a store goes to DONE and a load goes to WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i, capture formatted data into rdata_o and go to DONE. rvalid is guaranteed no earlier than the cycle after gnt.
- DONE: done_o=1, stall_o=0. valid_i is ignored because it still shows the completed instruction. Always returns to IDLE.
- Byte store: mem_be_o = 4'b0001 << addr_i[1:0]; mem_wdata_o = {4{wdata_i[7:0]}}.
- Word store: mem_be_o = 4'hF; mem_wdata_o = wdata_i.
- Loads drive mem_be_o = 4'hF.
- LBU: rdata_o = {24'd0, byte selected by addr_i[1:0]} (lane 0 = bits [7:0]).
- LW: rdata_o = mem_rdata_i.
- mem_rvalid_i outside WAIT is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (rdata_o = 32'd0).
- Reset mid-access: next edge returns to IDLE and mem_req_o drops. A stale rvalid arriving afterwards is ignored.
- Store with immediate gnt: accept at cycle 0, REQ at cycle 1, done_o at cycle 2. Stall lasts 2 cycles.
- Load with immediate gnt and rvalid the next cycle: done_o at cycle 3. Stall lasts 3 cycles.
- Each cycle gnt is withheld, or rvalid is delayed, adds one stall cycle.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle after DONE. Minimum issue interval is 3 cycles per store and 4 per load.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a word access with addr_i[1:0] != 0 goes IDLE -> DONE with no memory request. err_o=1 and done_o=1 in DONE, rdata_o is unchanged, and there is one stall cycle.
- Not defined: err_o is tied 0. addr_i[1:0] is ignored for word accesses, so the access is aligned down.

## Test plan
- SW, addr 0x0000_0104, wdata 0xDEADBEEF, gnt immediate -> mem_addr_o=0x041, be=4'hF, we=1, done_o at cycle 2, stall_o high for cycles 0-1.
- SB, addr 0x0000_0107, wdata 0x0000_00A5 -> be=4'b1000, mem_wdata_o=0xA5A5A5A5.
- LBU, addr 0x0000_0202, mem_rdata_i=0x11223344, gnt withheld 2 cycles, rvalid 3 cycles after gnt -> rdata_o=0x00000022, done_o at cycle 7.
- LW, addr 0x10 -> rdata_o=mem_rdata_i. Assert reset while in WAIT -> IDLE next cycle, mem_req_o=0, later rvalid produces no done_o.
- Non-memory valid_i, and load_i & store_i together -> stall_o=0, mem_req_o never asserted.
- LW at addr 0x0000_0006: with LSU_MISALIGN_TRAP_EN -> err_o and done_o at cycle 1, no request. Without it -> access at word address 0x001.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage driving a req/gnt/rvalid data-memory handshake and stalling upstream while busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned word accesses complete immediately with err_o instead of accessing memory.
module lsu_mem_stage #(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic                  byte_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t                r_state, w_next;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic                  r_we, r_byte;
  logic [1:0]            r_lane;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata, r_rdata;
  logic                  w_accept, w_mis;
  logic                  w_unused_addr;
  assign w_unused_addr = &{1'b0, addr_i[31:MEM_ADDR_W+2]};
  assign w_accept = (r_state == IDLE) && valid_i && (load_i ^ store_i);
`ifdef LSU_MISALIGN_TRAP_EN
  logic r_err;
  assign w_mis = !byte_i && (addr_i[1:0] != 2'd0);
  always_ff @(posedge clk)
    r_err <= reset ? 1'b0 : (w_accept ? w_mis : r_err);
  assign err_o = (r_state == DONE) && r_err;
`else
  assign w_mis = 1'b0;
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_mis ? DONE : REQ) : IDLE;
      REQ:     w_next = mem_gnt_i ? (r_we ? DONE : WAIT) : REQ;
      WAIT:    w_next = mem_rvalid_i ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    stall_o     = w_accept || (r_state == REQ) || (r_state == WAIT);
    done_o      = r_state == DONE;
    mem_req_o   = r_state == REQ;
    mem_we_o    = r_we;
    mem_addr_o  = r_addr;
    mem_be_o    = r_be;
    mem_wdata_o = r_wdata;
    rdata_o     = r_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_lane  <= 2'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr_i[MEM_ADDR_W+1:2];
        r_we    <= store_i;
        r_byte  <= byte_i;
        r_lane  <= addr_i[1:0];
        r_be    <= (store_i && byte_i) ? (4'b0001 << addr_i[1:0]) : 4'hF;
        r_wdata <= byte_i ? {4{wdata_i[7:0]}} : wdata_i;
      end
      if ((r_state == WAIT) && mem_rvalid_i)
        r_rdata <= r_byte ? {24'd0, mem_rdata_i[{r_lane, 3'b000} +: 8]} : mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed stimulus with a reactive memory model; a monitor checks requests and completions against queued expectations.
module tb_lsu_mem_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        valid_i = 0, load_i = 0, store_i = 0, byte_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic        stall_o, done_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic we; logic [9:0] addr; logic [3:0] be; logic chk_wd; logic [31:0] wdata;} req_t;
  typedef struct {logic chk_rd; logic [31:0] rdata; logic err;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  int gdly = 0, rdly = 1, gcnt = 0, rcnt = 0;
  bit pend = 0;
  logic [31:0] mrd = 0;

  lsu_mem_stage #(.MEM_ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
    .byte_i(byte_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic we, input logic [9:0] a, input logic [3:0] be, input logic cw, input logic [31:0] wd);
    req_t r;
    r.we = we; r.addr = a; r.be = be; r.chk_wd = cw; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic exp_rsp(input logic cr, input logic [31:0] rd, input logic er);
    rsp_t r;
    r.chk_rd = cr; r.rdata = rd; r.err = er;
    rsp_q.push_back(r);
  endtask

  // Memory model: grant after gdly cycles of request, rvalid rdly cycles after a load grant
  initial forever begin
    @(posedge clk); #1;
    mem_gnt_i = 0; mem_rvalid_i = 0;
    if (mem_req_o) begin
      if (gcnt == gdly) begin
        mem_gnt_i = 1; gcnt = 0;
        if (!mem_we_o) begin pend = 1; rcnt = 0; end
      end else gcnt++;
    end else if (pend) begin
      rcnt++;
      if (rcnt == rdly) begin mem_rvalid_i = 1; mem_rdata_i = mrd; pend = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (mem_req_o && req_q.size() == 0) check("unexpected_req", {31'd0, mem_req_o}, 32'd0);
      else if (mem_req_o && mem_gnt_i) begin
        req_t r;
        r = req_q.pop_front();
        check("req_we", {31'd0, mem_we_o}, {31'd0, r.we});
        check("req_addr", {22'd0, mem_addr_o}, {22'd0, r.addr});
        check("req_be", {28'd0, mem_be_o}, {28'd0, r.be});
        if (r.chk_wd) check("req_wdata", mem_wdata_o, r.wdata);
      end
      if (done_o && rsp_q.size() == 0) check("unexpected_done", {31'd0, done_o}, 32'd0);
      else if (done_o) begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_err", {31'd0, err_o}, {31'd0, r.err});
        if (r.chk_rd) check("rsp_rdata", rdata_o, r.rdata);
      end
      if (!done_o && err_o) check("err_outside_done", {31'd0, err_o}, 32'd0);
    end
  end

  task automatic op(input logic ld, input logic st, input logic by, input logic [31:0] a, input logic [31:0] wd,
                    input int g, input int r, input logic [31:0] md, input int exp_done);
    int k = 0, sc = 0;
    bit seen = 0;
    @(posedge clk); #1;
    gdly = g; rdly = r; mrd = md;
    valid_i = 1; load_i = ld; store_i = st; byte_i = by; addr_i = a; wdata_i = wd;
    while (!seen && k < 50) begin
      @(negedge clk);
      if (stall_o) sc++;
      if (done_o) seen = 1;
      else begin @(posedge clk); #1; k++; end
    end
    check("done_cycle", seen ? k : -1, exp_done);
    check("stall_cycles", sc, exp_done);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid_i = 0; load_i = 0; store_i = 0; byte_i = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_req", {31'd0, mem_req_o}, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_be_we", {27'd0, mem_be_o, mem_we_o}, 0);
    @(posedge clk); #1; reset = 0;

    exp_req(1, 10'h041, 4'hF, 1, 32'hDEADBEEF); exp_rsp(0, 0, 0);
    op(0, 1, 0, 32'h0000_0104, 32'hDEADBEEF, 0, 1, 0, 2);
    exp_req(1, 10'h041, 4'b1000, 1, 32'hA5A5A5A5); exp_rsp(0, 0, 0);
    op(0, 1, 1, 32'h0000_0107, 32'h0000_00A5, 0, 1, 0, 2);
    exp_req(0, 10'h080, 4'hF, 0, 0); exp_rsp(1, 32'h0000_0022, 0);
    op(1, 0, 1, 32'h0000_0202, 0, 2, 3, 32'h11223344, 7);
    exp_req(0, 10'h004, 4'hF, 0, 0); exp_rsp(1, 32'hCAFEF00D, 0);
    op(1, 0, 0, 32'h0000_0010, 0, 0, 1, 32'hCAFEF00D, 3);
    exp_req(1, 10'h000, 4'b0010, 1, 32'h3C3C3C3C); exp_rsp(0, 0, 0);
    op(0, 1, 1, 32'h0000_0001, 32'h1234_563C, 0, 1, 0, 2);
    check("rdata_hold", rdata_o, 32'hCAFEF00D);
    exp_req(0, 10'h000, 4'hF, 0, 0); exp_rsp(1, 32'h0000_0088, 0);
    op(1, 0, 1, 32'h0000_0003, 0, 0, 1, 32'h8899AABB, 3);

    @(posedge clk); #1; valid_i = 1; load_i = 0; store_i = 0;
    @(negedge clk); check("noop_stall", {31'd0, stall_o}, 0); check("noop_req", {31'd0, mem_req_o}, 0);
    @(posedge clk); #1; load_i = 1; store_i = 1;
    @(negedge clk); check("both_stall", {31'd0, stall_o}, 0);
    @(posedge clk); #1;
    @(negedge clk); check("both_req", {31'd0, mem_req_o}, 0);
    idle();

`ifdef LSU_MISALIGN_TRAP_EN
    exp_rsp(1, 32'h0000_0088, 1);
    op(1, 0, 0, 32'h0000_0006, 0, 0, 1, 32'h55AA55AA, 1);
`else
    exp_req(0, 10'h001, 4'hF, 0, 0); exp_rsp(1, 32'h55AA55AA, 0);
    op(1, 0, 0, 32'h0000_0006, 0, 0, 1, 32'h55AA55AA, 3);
`endif
    idle();

    exp_req(0, 10'h008, 4'hF, 0, 0);
    @(posedge clk); #1; gdly = 0; rdly = 4; mrd = 32'h12345678;
    valid_i = 1; load_i = 1; store_i = 0; byte_i = 0; addr_i = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1; valid_i = 0; load_i = 0;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("rstw_req", {31'd0, mem_req_o}, 0);
    check("rstw_stall", {31'd0, stall_o}, 0);
    check("rstw_rdata", rdata_o, 0);
    repeat (5) begin @(negedge clk); check("stale_rvalid_done", {31'd0, done_o}, 0); end

    repeat (3) @(posedge clk);
    check("req_q_empty", req_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
